// File: rtl/Coefficients_Fx.sv
// Estimation-filter tap tables for the control-bounded ADC, one row per comparator channel.
// Taps are dyadic so the float sums stay exact; odd channels carry half weight.
package Coefficients_Fx;
   localparam int N = 2;

   function automatic real hb(input int i, input int k);
      real s;
      s = (k % 5 == 4) ? -1.0 : 1.0;
      return s * ((i % 2 == 1) ? 0.5 : 1.0) / real'(2 << (k % 8));
   endfunction

   function automatic real hf(input int i, input int k);
      real s;
      s = (k % 3 == 2) ? -1.0 : 1.0;
      return s * ((i % 2 == 1) ? 0.5 : 1.0) / real'(4 << (k % 8));
   endfunction
endpackage

// File: rtl/fir_flp_filter.sv
// Linear-phase FIR estimator (lookback + lookahead taps per channel) with a float adder tree.
// Latency clog2(N*(Lookahead+Lookback))+2 clocks from newest-sample capture; no backpressure.
module fir_flp_filter #(
   parameter int N         = Coefficients_Fx::N,
   parameter int Lookahead = 220,
   parameter int Lookback  = 220,
   parameter int DSR       = 1,
   parameter int n_exp     = 8,
   parameter int n_mant    = 23
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          in,
   output logic [n_exp+n_mant:0] out,
   output logic                  valid
);
   localparam int W      = 1 + n_exp + n_mant;
   localparam int SW     = n_mant + 4;
   localparam int EMAX   = (1 << n_exp) - 1;
   localparam int BIAS   = (1 << (n_exp - 1)) - 1;
   localparam int D      = Lookahead + Lookback;
   localparam int T      = N * D;
   localparam int LEVELS = $clog2(T);
   localparam int P      = 1 << LEVELS;
   localparam int FW     = $clog2(D + 1);
   localparam int DW     = (DSR > 1) ? $clog2(DSR) : 1;
   localparam logic [n_exp-1:0] EONES = '1;

   function automatic logic [W-1:0] real_to_fp(input real v);
      logic [63:0] b;
      int          e;
      b = $realtobits(v);
      e = int'(b[62:52]) - 1023 + BIAS;
      if (b[62:52] == 11'd0 || e <= 0) return {b[63], {(W-1){1'b0}}};
      if (e >= EMAX) return {b[63], EONES, {n_mant{1'b0}}};
      return {b[63], e[n_exp-1:0], n_mant'(b[51:0] >> (52 - n_mant))};
   endfunction

   // Age 0 is the newest sample, which pairs with the last lookahead tap.
   function automatic real tap_coef(input int ch, input int a);
      if (a < Lookahead) return Coefficients_Fx::hf(ch, Lookahead - 1 - a);
      return Coefficients_Fx::hb(ch, a - Lookahead);
   endfunction

   // Round-to-nearest-even add; subnormals read and flush as zero, overflow gives infinity.
   function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0]      x, y, r;
      logic [SW-1:0]     bx, by, sh, lost;
      logic [SW:0]       s;
      logic [n_mant+1:0] rs;
      logic              rnd;
      int                d, e;
      if (a[W-2:0] >= b[W-2:0]) begin
         x = a; y = b;
      end else begin
         x = b; y = a;
      end
      e  = int'(x[W-2:n_mant]);
      d  = e - int'(y[W-2:n_mant]);
      bx = {1'b1, x[n_mant-1:0], 3'b000};
      by = {1'b1, y[n_mant-1:0], 3'b000};
      if (d >= SW) begin
         sh   = '0;
         lost = by;
      end else begin
         sh   = by >> d;
         lost = by & ~({SW{1'b1}} << d);
      end
      sh[0] = sh[0] | (|lost);
      if (x[W-1] == y[W-1]) s = {1'b0, bx} + {1'b0, sh};
      else                  s = {1'b0, bx} - {1'b0, sh};
      if (s[SW]) begin
         s = {1'b0, s[SW:2], s[1] | s[0]};
         e = e + 1;
      end
      for (int i = 0; i < SW; i++) begin
         if (!s[SW-1]) begin
            s = s << 1;
            e = e - 1;
         end
      end
      rnd = s[2] & (s[1] | s[0] | s[3]);
      rs  = {1'b0, s[SW-1:3]} + {{(n_mant+1){1'b0}}, rnd};
      if (rs[n_mant+1]) e = e + 1;
      if (x[W-2:n_mant] == EONES)
         r = x;
      else if (y[W-2:n_mant] == '0)
         r = (x[W-2:n_mant] == '0) ? {x[W-1] & y[W-1], {(W-1){1'b0}}} : x;
      else if (s == '0)
         r = '0;
      else if (e <= 0)
         r = {x[W-1], {(W-1){1'b0}}};
      else if (e >= EMAX)
         r = {x[W-1], EONES, {n_mant{1'b0}}};
      else
         r = {x[W-1], e[n_exp-1:0], rs[n_mant+1] ? rs[n_mant:1] : rs[n_mant-1:0]};
      return r;
   endfunction

   logic [D-1:0]  hist_q [N];
   logic [D-1:0]  hist_d [N];
   logic [FW-1:0] fill_q, fill_d;
   logic [DW-1:0] dec_q, dec_d;
   logic          full, issue;
   logic [W-1:0]  term_d [P];
   logic [W-1:0]  node_q [2*P-1];
   logic [W-1:0]  node_d [2*P-1];
   logic [LEVELS:0] vld_q, vld_d;
   logic [W-1:0]  out_q, out_d;
   logic          valid_q, valid_d;

   assign full  = (fill_q == FW'(D));
   assign issue = full && (dec_q == '0);

   always_comb begin
      fill_d = full ? fill_q : fill_q + FW'(1);
      dec_d  = dec_q;
      if (full) dec_d = (dec_q == DW'(DSR - 1)) ? '0 : dec_q + DW'(1);
      for (int ch = 0; ch < N; ch++) hist_d[ch] = {hist_q[ch][D-2:0], in[ch]};
   end

   for (genvar ch = 0; ch < N; ch++) begin : g_ch
      for (genvar a = 0; a < D; a++) begin : g_tap
         localparam logic [W-1:0] C = real_to_fp(tap_coef(ch, a));
         assign term_d[ch*D+a] = hist_q[ch][a] ? C : {~C[W-1], C[W-2:0]};
      end
   end
   for (genvar p = T; p < P; p++) begin : g_pad
      assign term_d[p] = '0;
   end

   // Level lv of the tree occupies node indices [2P - 2P/2^lv, 2P - P/2^lv).
   always_comb begin
      int src;
      int dst;
      src = 0;
      dst = P;
      for (int i = 0; i < P; i++) node_d[i] = term_d[i];
      for (int lv = 1; lv <= LEVELS; lv++) begin
         for (int j = 0; j < (P >> lv); j++)
            node_d[dst+j] = fp_add(node_q[src+2*j], node_q[src+2*j+1]);
         src = dst;
         dst = dst + (P >> lv);
      end
   end

   always_comb begin
      vld_d   = {vld_q[LEVELS-1:0], issue};
      valid_d = vld_q[LEVELS];
      out_d   = vld_q[LEVELS] ? node_q[2*P-2] : out_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int ch = 0; ch < N; ch++) hist_q[ch] <= '0;
         for (int i = 0; i < 2*P-1; i++) node_q[i] <= '0;
         fill_q  <= '0;
         dec_q   <= '0;
         vld_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         node_q  <= node_d;
         fill_q  <= fill_d;
         dec_q   <= dec_d;
         vld_q   <= vld_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
endmodule

// File: tb/tb_fir_flp_filter.sv
// Bench for fir_flp_filter: vector tables on a 1-channel 1/1-tap build, a DSR=4 sequence,
// and a random run of the default build against a real-arithmetic reference.
module tb_fir_flp_filter;
   localparam int NC = Coefficients_Fx::N;
   localparam int LA = 220;
   localparam int LB = 220;
   localparam int DC = LA + LB;
   localparam int LC = $clog2(NC * DC) + 2;
   localparam logic [31:0] P75 = 32'h3F40_0000;
   localparam logic [31:0] M75 = 32'hBF40_0000;
   localparam logic [31:0] P25 = 32'h3E80_0000;
   localparam logic [31:0] M25 = 32'hBE80_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a, rst_b, rst_c;
   logic [0:0]    in_a, in_b;
   logic [NC-1:0] in_c;
   logic [31:0]   out_a, out_b, out_c;
   logic          valid_a, valid_b, valid_c;

   fir_flp_filter #(.N(1), .Lookahead(1), .Lookback(1), .DSR(1)) u_a (
      .clk(clk), .rst(rst_a), .in(in_a), .out(out_a), .valid(valid_a));
   fir_flp_filter #(.N(1), .Lookahead(1), .Lookback(1), .DSR(4)) u_b (
      .clk(clk), .rst(rst_b), .in(in_b), .out(out_b), .valid(valid_b));
   fir_flp_filter u_c (
      .clk(clk), .rst(rst_c), .in(in_c), .out(out_c), .valid(valid_c));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic int ulp_key(input logic [31:0] f);
      return f[31] ? -int'(f[30:0]) : int'(f[30:0]);
   endfunction

   task automatic check_ulp(input string name, input logic [31:0] act, input logic [31:0] exp);
      int d;
      n_cmp++;
      d = ulp_key(act) - ulp_key(exp);
      if ($isunknown(act) || d > 2 || d < -2) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (+-2 ulp)", name, act, exp);
      end
   endtask

   function automatic logic [31:0] to_fp32(input real v);
      logic [63:0] b;
      int          e;
      b = $realtobits(v);
      e = int'(b[62:52]) - 1023 + 127;
      if (v == 0.0 || e <= 0) return {b[63], 31'd0};
      if (e >= 255) return {b[63], 8'hFF, 23'd0};
      return {b[63], e[7:0], b[51:29]};
   endfunction

   typedef struct {
      logic        r;
      logic        x;
      logic        ev;
      logic [31:0] eo;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r, input logic x, input logic ev, input logic [31:0] eo);
      tbl.push_back('{r, x, ev, eo});
   endtask

   // Reference for the default build: whole sample history, estimate formula in real arithmetic.
   real cb [NC][LB];
   real cf [NC][LA];
   logic [NC-1:0] sq[$];
   typedef struct {
      int          due;
      logic [31:0] val;
   } exp_t;
   exp_t        eq[$];
   int          cyc_c = 0;
   logic [31:0] last_c = '0;

   function automatic real ref_est();
      int  n;
      int  c;
      real y;
      n = sq.size();
      c = n - 1 - LA;
      y = 0.0;
      for (int i = 0; i < NC; i++) begin
         for (int k = 0; k < LB; k++) y += cb[i][k] * (sq[c-k][i] ? 1.0 : -1.0);
         for (int k = 0; k < LA; k++) y += cf[i][k] * (sq[c+1+k][i] ? 1.0 : -1.0);
      end
      return y;
   endfunction

   task automatic step_c();
      @(posedge clk);
      #1;
      cyc_c++;
      if (rst_c) begin
         sq.delete();
         eq.delete();
         last_c = '0;
      end else begin
         sq.push_back(in_c);
         if (sq.size() >= DC) eq.push_back('{cyc_c + LC, to_fp32(ref_est())});
      end
      if (eq.size() > 0 && eq[0].due == cyc_c) begin
         check($sformatf("c[%0d].valid", cyc_c), {31'd0, valid_c}, 32'd1);
         check_ulp($sformatf("c[%0d].out", cyc_c), out_c, eq[0].val);
         last_c = eq[0].val;
         void'(eq.pop_front());
      end else begin
         check($sformatf("c[%0d].valid", cyc_c), {31'd0, valid_c}, 32'd0);
         check_ulp($sformatf("c[%0d].hold", cyc_c), out_c, last_c);
      end
   endtask

   initial begin
      rst_a = 1'b1; in_a = '0;
      rst_b = 1'b1; in_b = '0;
      rst_c = 1'b1; in_c = '0;
      for (int i = 0; i < NC; i++) begin
         for (int k = 0; k < LB; k++) cb[i][k] = Coefficients_Fx::hb(i, k);
         for (int k = 0; k < LA; k++) cf[i][k] = Coefficients_Fx::hf(i, k);
      end

      // hb=0.5 on the older sample, hf=0.25 on the newer; valid first appears 5 edges after release.
      repeat (3) add(1, 1, 0, 32'h0);
      repeat (4) add(0, 1, 0, 32'h0);
      add(0, 1, 1, P75);
      repeat (3) add(0, 0, 1, P75);
      add(0, 1, 1, P25);
      add(0, 0, 1, M75);
      add(0, 1, 1, M75);
      add(0, 0, 1, M25);
      add(0, 1, 1, P25);
      add(0, 0, 1, M25);
      add(0, 0, 1, P25);
      add(0, 0, 1, M25);
      add(1, 0, 0, 32'h0);
      repeat (4) add(0, 0, 0, 32'h0);
      repeat (2) add(0, 0, 1, M75);

      for (int i = 0; i < tbl.size(); i++) begin
         rst_a = tbl[i].r;
         in_a  = tbl[i].x;
         @(posedge clk);
         #1;
         check($sformatf("a[%0d].valid", i), {31'd0, valid_a}, {31'd0, tbl[i].ev});
         check($sformatf("a[%0d].out", i), out_a, tbl[i].eo);
      end
      rst_a = 1'b1;

      // DSR=4: one pulse every 4 clocks from edge 5 on, out held in between.
      rst_b = 1'b1;
      in_b  = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("b.reset_valid", {31'd0, valid_b}, 32'd0);
         check("b.reset_out", out_b, 32'd0);
      end
      rst_b = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("b[%0d].valid", e), {31'd0, valid_b},
               (e >= 5 && (e - 5) % 4 == 0) ? 32'd1 : 32'd0);
         check($sformatf("b[%0d].out", e), out_b, (e >= 5) ? P75 : 32'd0);
      end
      rst_b = 1'b1;

      rst_c = 1'b1;
      repeat (3) begin
         in_c = NC'($urandom);
         step_c();
      end
      for (int s = 0; s < 24000; s++) begin
         rst_c = (s == 5000);
         in_c  = NC'($urandom);
         step_c();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
